// File: rtl/pwm_output_stage_if.sv
// Configuration/output bundle between the SPI register block (master) and the PWM output stage (slave).
// Optional macro PWM_PERIOD_TICK_EN adds the pwm_period_tick signal.
interface pwm_output_stage_if;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic [7:0] out_7_0;
    logic [7:0] out_15_8;
`ifdef PWM_PERIOD_TICK_EN
    logic       pwm_period_tick;
`endif

    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        input  out_7_0, out_15_8
`ifdef PWM_PERIOD_TICK_EN
        , input pwm_period_tick
`endif
    );

    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        output out_7_0, out_15_8
`ifdef PWM_PERIOD_TICK_EN
        , output pwm_period_tick
`endif
    );
endinterface

// File: rtl/pwm_output_stage.sv
// 16-output PWM stage: per-output force-low / static-high / shared PWM, duty double-buffered at period boundary.
// Optional macro PWM_PERIOD_TICK_EN adds a one-clk pulse on the first output cycle of each new period.
module pwm_output_stage #(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic               clk,
    input  logic               rst_n,
    pwm_output_stage_if.slave  bus
);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [7:0]  CNT_LAST = 8'd254;

    logic [15:0] prescaler_reg;
    logic [7:0]  pwm_cnt_reg;
    logic [7:0]  duty_shadow_reg;
    logic [15:0] out_reg;

    logic        step;
    logic        boundary;
    logic        pwm_sig;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] next_out;

    assign step     = (prescaler_reg == DIV_LAST);
    assign boundary = step && (pwm_cnt_reg == CNT_LAST);
    // Counter tops out at 254, so duty 0xFF keeps the signal high all period.
    assign pwm_sig  = (pwm_cnt_reg < duty_shadow_reg);
    assign en_out   = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm   = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    for (genvar gi = 0; gi < 16; gi++) begin : g_out
        assign next_out[gi] = en_out[gi] & (en_pwm[gi] ? pwm_sig : 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_reg   <= 16'd0;
            pwm_cnt_reg     <= 8'd0;
            duty_shadow_reg <= 8'd0;
            out_reg         <= 16'd0;
        end else begin
            out_reg <= next_out;
            if (step) begin
                prescaler_reg <= 16'd0;
                pwm_cnt_reg   <= (pwm_cnt_reg == CNT_LAST) ? 8'd0 : pwm_cnt_reg + 8'd1;
            end else begin
                prescaler_reg <= prescaler_reg + 16'd1;
            end
            if (boundary) begin
                duty_shadow_reg <= bus.pwm_duty_cycle;
            end
        end
    end

    assign bus.out_7_0  = out_reg[7:0];
    assign bus.out_15_8 = out_reg[15:8];

`ifdef PWM_PERIOD_TICK_EN
    // Two stages: the new duty reaches the outputs one clk after the boundary edge.
    logic period_start_reg;
    logic tick_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start_reg <= 1'b0;
            tick_reg         <= 1'b0;
        end else begin
            period_start_reg <= boundary;
            tick_reg         <= period_start_reg;
        end
    end

    assign bus.pwm_period_tick = tick_reg;
`endif
endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage with a cycle-count based reference model checked every cycle.
module tb_pwm_output_stage;
    localparam int CLK_DIV = 2;
    localparam int PERIOD  = 255 * CLK_DIV;

    logic clk;
    logic rst_n;

    pwm_output_stage_if bus ();

    pwm_output_stage #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [15:0] outv = {bus.out_15_8, bus.out_7_0};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: waveform position derived from number of clk edges since reset release.
    int          m_edges;
    logic [7:0]  m_shadow;
    logic [15:0] exp_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges  = 0;
            m_shadow = 8'd0;
            exp_out  = 16'd0;
        end else begin
            int cnt;
            logic sig;
            logic [15:0] eo;
            logic [15:0] ep;
            cnt = (m_edges / CLK_DIV) % 255;
            sig = (cnt < int'(m_shadow));
            eo  = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
            ep  = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
            for (int i = 0; i < 16; i++)
                exp_out[i] = eo[i] & (ep[i] ? sig : 1'b1);
            if ((m_edges + 1) % PERIOD == 0)
                m_shadow = bus.pwm_duty_cycle;
            m_edges = m_edges + 1;
        end
    end

    // Per-cycle compare against the model.
    int model_prints = 0;
    always @(negedge clk) begin
        n_cmp = n_cmp + 1;
        if (outv !== exp_out) begin
            n_bad = n_bad + 1;
            if (model_prints < 20) begin
                model_prints = model_prints + 1;
                $display("FAIL model_cycle t=%0t out=%h expected=%h", $time, outv, exp_out);
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_cmp = n_cmp + 1;
        if (actual != expected) begin
            n_bad = n_bad + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end else begin
            $display("ok   %s = %0d", name, actual);
        end
    endtask

    task automatic count_run(input int b, input logic val, output int len);
        len = 0;
        while (outv[b] == val && len < 5000) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_val(input string name, input int b, input logic val);
        int k;
        k = 0;
        while (outv[b] != val && k < 5000) begin
            k++;
            @(negedge clk);
        end
        if (outv[b] != val) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL %s timeout out=%h wanted bit%0d=%0b", name, outv, b, val);
        end
    endtask

    task automatic set_cfg(input logic [7:0] eo_lo, input logic [7:0] eo_hi,
                           input logic [7:0] ep_lo, input logic [7:0] ep_hi,
                           input logic [7:0] duty);
        bus.en_reg_out_7_0  = eo_lo;
        bus.en_reg_out_15_8 = eo_hi;
        bus.en_reg_pwm_7_0  = ep_lo;
        bus.en_reg_pwm_15_8 = ep_hi;
        bus.pwm_duty_cycle  = duty;
    endtask

    initial begin
        int r;
        int hi;
        int lo;
        int other;

        // Reset with all inputs high.
        rst_n = 1'b0;
        set_cfg(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (4) @(negedge clk);
        check("reset_out", int'(outv), 0);
        rst_n = 1'b1;
        @(negedge clk);
        count_run(0, 1'b0, r);
        check("first_period_low_clk", r, PERIOD);
        check("after_first_period_out", int'(outv), 16'hFFFF);

        // Static mode.
        set_cfg(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        check("static_out_7_0", int'(bus.out_7_0), 8'hA5);
        check("static_out_15_8", int'(bus.out_15_8), 0);
        repeat (10) @(negedge clk);
        check("static_out_7_0_hold", int'(bus.out_7_0), 8'hA5);

        // PWM duty 0x80 on output 8.
        set_cfg(8'h00, 8'h01, 8'h00, 8'h01, 8'h80);
        @(negedge clk);
        wait_val("duty80_fall", 8, 1'b0);
        wait_val("duty80_rise", 8, 1'b1);
        count_run(8, 1'b1, r);
        check("duty80_high_clk", r, 256);
        count_run(8, 1'b0, r);
        check("duty80_low_clk", r, 254);

        // Duty 0x00 -> always low.
        bus.pwm_duty_cycle = 8'h00;
        repeat (PERIOD * 2 + 80) @(negedge clk);
        hi = 0;
        repeat (PERIOD) begin
            if (outv[8]) hi++;
            @(negedge clk);
        end
        check("duty00_high_clk", hi, 0);

        // Duty 0xFF -> always high.
        bus.pwm_duty_cycle = 8'hFF;
        repeat (PERIOD * 2 + 80) @(negedge clk);
        lo = 0;
        repeat (PERIOD) begin
            if (!outv[8]) lo++;
            @(negedge clk);
        end
        check("dutyFF_low_clk", lo, 0);

        // Double buffer: 0x40 running, 0xC0 written around pwm_cnt=10.
        bus.pwm_duty_cycle = 8'h40;
        repeat (PERIOD * 2 + 80) @(negedge clk);
        wait_val("db_fall", 8, 1'b0);
        wait_val("db_rise", 8, 1'b1);
        hi = 0;
        repeat (20) begin
            if (outv[8]) hi++;
            @(negedge clk);
        end
        bus.pwm_duty_cycle = 8'hC0;
        count_run(8, 1'b1, r);
        check("db_old_high_clk", hi + r, 128);
        count_run(8, 1'b0, r);
        check("db_old_low_clk", r, 382);
        count_run(8, 1'b1, r);
        check("db_new_high_clk", r, 384);

        // Mixed: en_out=0x00FF, en_pwm=0xFFFF, duty 0x80.
        set_cfg(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h80);
        repeat (PERIOD * 2 + 80) @(negedge clk);
        hi = 0; lo = 0; other = 0;
        repeat (PERIOD) begin
            if (bus.out_7_0 == 8'hFF) hi++;
            if (bus.out_7_0 == 8'h00) lo++;
            if (bus.out_15_8 != 8'h00) other++;
            @(negedge clk);
        end
        check("mixed_high_clk", hi, 256);
        check("mixed_low_clk", lo, 254);
        check("mixed_upper_nonzero_clk", other, 0);
        wait_val("mixed_low", 0, 1'b0);
        bus.en_reg_pwm_7_0 = 8'h00;
        @(negedge clk);
        check("mode_override_out_7_0", int'(bus.out_7_0), 8'hFF);

        // Reset mid-period with outputs high.
        set_cfg(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        repeat (PERIOD * 2 + 80) @(negedge clk);
        check("pre_reset_out", int'(outv), 16'hFFFF);
        repeat (200) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_out", int'(outv), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        count_run(0, 1'b0, r);
        check("post_reset_low_clk", r, PERIOD);
        check("post_reset_out", int'(outv), 16'hFFFF);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_output_stage.md
Name: pwm_output_stage

Overview:
- Downstream consumer of the SPI register block; takes its five 8-bit configuration registers and drives 16 chip outputs.
- Each output can be forced low, driven static high, or driven by a shared 8-bit PWM waveform.
- Duty-cycle updates are double-buffered and applied only at a PWM period boundary, so output pulses never glitch.

Parameters:
- CLK_DIV, 3000: clk cycles per PWM counter step. Legal range 1..65535. 1 means the counter steps every clk.

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- en_reg_out_7_0  input  8  output enable, bits 7:0.
- en_reg_out_15_8  input  8  output enable, bits 15:8.
- en_reg_pwm_7_0  input  8  PWM mode select, bits 7:0.
- en_reg_pwm_15_8  input  8  PWM mode select, bits 15:8.
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF.
- out_7_0  output  8  driven outputs 7:0, registered.
- out_15_8  output  8  driven outputs 15:8, registered.

Behaviour:
- Inputs are synchronous to clk (the register block runs on the same clk); no synchronisers.
- Reset (async assert, sync release): prescaler=0, pwm_cnt=0, duty_shadow=0x00, out_7_0=0x00, out_15_8=0x00.
- Prescaler: 16-bit counter, 0..CLK_DIV-1.
  - step = (prescaler == CLK_DIV-1).
  - On step the prescaler wraps to 0.
- pwm_cnt: 8-bit, advances only on step.
  - Sequence 0..254, then wraps to 0. The period is 255 steps = 255*CLK_DIV clk.
  - The value 255 is never reached.
- Period boundary: the step on which pwm_cnt goes 254->0.
  - On that same clk edge, duty_shadow <= pwm_duty_cycle.
  - Changes to pwm_duty_cycle at any other time do not affect the waveform until the next boundary.
  - duty_shadow is also 0 after reset, so output stays low for the whole first period.
- pwm_sig (combinational) = (pwm_cnt < duty_shadow), unsigned 8-bit compare.
  - duty 0x00: always 0.
  - duty 0xFF: always 1, since pwm_cnt max is 254.
  - duty d: high for exactly d of 255 steps, at the start of the period.
- Per output i (0..15), with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - next_out[i] = en_out[i] & (en_pwm[i] ? pwm_sig : 1).
  - en_out=0 forces low regardless of en_pwm.
- Outputs are registered: {out_15_8,out_7_0} <= next_out every clk.
  - Latency is 1 clk from an en_reg_* change, or from a pwm_cnt/duty_shadow update, to the outputs.
- Enable and mode changes are not period-aligned; they take effect after 1 clk.
- Reset mid-operation: everything returns to reset values immediately, and the waveform restarts at pwm_cnt=0 after release.
- Simultaneous duty write and boundary on the same edge: the shadow captures the new value present on pwm_duty_cycle at that edge.

Optional Feature:
- Macro: PWM_PERIOD_TICK_EN.
- Defined:
  - Adds output port pwm_period_tick (1 bit).
  - Registered, one-clk pulse asserted the cycle after each period boundary, i.e. aligned with the first output cycle of the new duty.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with all inputs 0xFF -> out_7_0=out_15_8=0x00. After release, outputs stay 0 for the first 255*CLK_DIV clk (duty_shadow=0), then go 0xFF/0xFF.
- Static mode: CLK_DIV=2, en_reg_out_7_0=0xA5, en_reg_pwm_*=0, others 0 -> out_7_0=0xA5 one clk after the write and constant; out_15_8=0x00.
- PWM duty: CLK_DIV=2, en_reg_out_15_8=0x01, en_reg_pwm_15_8=0x01, duty=0x80, after one boundary -> out_15_8[0] high 256 clk, low 254 clk, period 510 clk. Check duty 0x00 gives always low and 0xFF always high.
- Double buffer: duty 0x40 running; write 0xC0 at pwm_cnt=10 -> current period keeps 64-step high time; 192-step high time starts exactly at the next boundary.
- Mixed/mode override: en_out=0x00FF, en_pwm=0xFFFF, duty 0x80 -> bits 7:0 toggle, bits 15:8 stay 0. Clearing en_pwm_7_0 mid-period -> bits 7:0 static high after 1 clk.
- Reset mid-period: assert rst_n at pwm_cnt=100 with outputs high -> outputs 0 immediately (async). After release, the first period is low. With PWM_PERIOD_TICK_EN, the tick pulses once per 255*CLK_DIV clk and is never high during reset.
